// File: rtl/fetch_ctrl.sv
// Fetch sequencer driving prog_counter: boots to the reset vector, arbitrates
// exception/branch/jump redirects and parks a redirect that meets a stall.
module fetch_ctrl #(
  parameter int                     PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0]    RESET_VECTOR = 32'h0000_0000,
  parameter logic [PC_WIDTH-1:0]    EXC_VECTOR   = 32'h0000_0080,
  parameter int                     BOOT_CYCLES  = 2
) (
  input  logic                fc_clk,
  input  logic                fc_rst,
  input  logic                fc_i_stall,
  input  logic                fc_i_imem_rdy,
  input  logic                fc_i_exc,
  input  logic                fc_i_br_taken,
  input  logic [PC_WIDTH-1:0] fc_i_br_target,
  input  logic                fc_i_jmp,
  input  logic [PC_WIDTH-1:0] fc_i_jmp_target,
  output logic                fc_o_ce,
  output logic                fc_o_change_pc,
  output logic [PC_WIDTH-1:0] fc_o_pc,
  output logic                fc_o_flush_if,
  output logic                fc_o_flush_id,
  output logic [1:0]          fc_o_state,
  output logic                fc_o_pending
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10
  } state_t;

  localparam logic [1:0] KIND_JMP = 2'd0;
  localparam logic [1:0] KIND_BR  = 2'd1;
  localparam logic [1:0] KIND_EXC = 2'd2;
  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES);

  state_t              state_r, state_nxt_s;
  logic [3:0]          cnt_r, cnt_nxt_s;
  logic                pend_valid_r, pend_valid_nxt_s;
  logic [1:0]          pend_kind_r, pend_kind_nxt_s;
  logic [PC_WIDTH-1:0] pend_target_r, pend_target_nxt_s;

  logic                go_s;
  logic                live_valid_s;
  logic [1:0]          live_kind_s;
  logic [PC_WIDTH-1:0] live_target_s;
  logic                issue_s;
  logic                boot_fire_s;
  logic [1:0]          sel_kind_s;
  logic [PC_WIDTH-1:0] sel_target_s;

  // Only exceptions and branches have a wrong-path instruction already in ID.
  function automatic logic kind_flushes_id(input logic [1:0] kind);
    return (kind != KIND_JMP);
  endfunction

  assign go_s = !fc_i_stall && fc_i_imem_rdy;

  // Priority encode the live redirect requests: exc > br > jmp.
  always_comb begin
    live_valid_s  = fc_i_exc || fc_i_br_taken || fc_i_jmp;
    live_kind_s   = KIND_JMP;
    live_target_s = fc_i_jmp_target;
    if (fc_i_exc) begin
      live_kind_s   = KIND_EXC;
      live_target_s = EXC_VECTOR;
    end else if (fc_i_br_taken) begin
      live_kind_s   = KIND_BR;
      live_target_s = fc_i_br_target;
    end else begin
      live_kind_s   = KIND_JMP;
      live_target_s = fc_i_jmp_target;
    end
  end

  // Next-state, pending-register update and issue selection.
  always_comb begin
    state_nxt_s       = state_r;
    cnt_nxt_s         = cnt_r;
    pend_valid_nxt_s  = pend_valid_r;
    pend_kind_nxt_s   = pend_kind_r;
    pend_target_nxt_s = pend_target_r;
    issue_s           = 1'b0;
    boot_fire_s       = 1'b0;
    sel_kind_s        = live_kind_s;
    sel_target_s      = live_target_s;
    case (state_r)
      ST_BOOT: begin
        if (cnt_r >= BOOT_LAST) begin
          boot_fire_s = 1'b1;
          cnt_nxt_s   = 4'd0;
          state_nxt_s = ST_RUN;
        end else begin
          cnt_nxt_s = cnt_r + 4'd1;
        end
      end
      ST_RUN: begin
        if (live_valid_s && go_s) begin
          issue_s = 1'b1;
        end else if (live_valid_s) begin
          pend_valid_nxt_s  = 1'b1;
          pend_kind_nxt_s   = live_kind_s;
          pend_target_nxt_s = live_target_s;
          state_nxt_s       = ST_HOLD;
        end else begin
          issue_s = 1'b0;
        end
      end
      ST_HOLD: begin
        if (go_s) begin
          issue_s          = 1'b1;
          pend_valid_nxt_s = 1'b0;
          state_nxt_s      = ST_RUN;
          if (!(live_valid_s && (live_kind_s >= pend_kind_r))) begin
            sel_kind_s   = pend_kind_r;
            sel_target_s = pend_target_r;
          end else begin
            sel_kind_s   = live_kind_s;
            sel_target_s = live_target_s;
          end
        end else if (live_valid_s && (live_kind_s >= pend_kind_r)) begin
          pend_kind_nxt_s   = live_kind_s;
          pend_target_nxt_s = live_target_s;
        end else begin
          issue_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s      = ST_BOOT;
        cnt_nxt_s        = 4'd0;
        pend_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // Drive prog_counter controls and flushes from the decisions above.
  always_comb begin
    fc_o_ce        = 1'b0;
    fc_o_change_pc = 1'b0;
    fc_o_pc        = '0;
    fc_o_flush_if  = 1'b0;
    fc_o_flush_id  = 1'b0;
    if (boot_fire_s) begin
      fc_o_ce        = 1'b1;
      fc_o_change_pc = 1'b1;
      fc_o_pc        = RESET_VECTOR;
      fc_o_flush_if  = 1'b1;
      fc_o_flush_id  = 1'b1;
    end else if (issue_s) begin
      fc_o_ce        = 1'b1;
      fc_o_change_pc = 1'b1;
      fc_o_pc        = sel_target_s;
      fc_o_flush_if  = 1'b1;
      fc_o_flush_id  = kind_flushes_id(sel_kind_s);
    end else if (state_r == ST_RUN) begin
      fc_o_ce = go_s && !live_valid_s;
    end else begin
      fc_o_ce = 1'b0;
    end
  end

  assign fc_o_state   = state_r;
  assign fc_o_pending = pend_valid_r;

  // State, boot counter and pending redirect registers.
  always_ff @(posedge fc_clk or negedge fc_rst) begin
    if (!fc_rst) begin
      state_r       <= ST_BOOT;
      cnt_r         <= 4'd0;
      pend_valid_r  <= 1'b0;
      pend_kind_r   <= KIND_JMP;
      pend_target_r <= '0;
    end else begin
      state_r       <= state_nxt_s;
      cnt_r         <= cnt_nxt_s;
      pend_valid_r  <= pend_valid_nxt_s;
      pend_kind_r   <= pend_kind_nxt_s;
      pend_target_r <= pend_target_nxt_s;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: expected output vectors are queued as each
// step is driven and compared against the DUT mid-cycle.
module tb_fetch_ctrl;

  logic        fc_clk = 1'b0;
  logic        fc_rst;
  logic        fc_i_stall, fc_i_imem_rdy, fc_i_exc, fc_i_br_taken, fc_i_jmp;
  logic [31:0] fc_i_br_target, fc_i_jmp_target;
  logic        fc_o_ce, fc_o_change_pc, fc_o_flush_if, fc_o_flush_id, fc_o_pending;
  logic [31:0] fc_o_pc;
  logic [1:0]  fc_o_state;

  typedef struct packed {
    logic        ce;
    logic        chg;
    logic [31:0] pc;
    logic        fif;
    logic        fid;
    logic [1:0]  st;
    logic        pend;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    total = 0;
  int    bad   = 0;

  fetch_ctrl #(.PC_WIDTH(32), .RESET_VECTOR(32'h0), .EXC_VECTOR(32'h80), .BOOT_CYCLES(2)) dut (
    .fc_clk(fc_clk), .fc_rst(fc_rst),
    .fc_i_stall(fc_i_stall), .fc_i_imem_rdy(fc_i_imem_rdy),
    .fc_i_exc(fc_i_exc), .fc_i_br_taken(fc_i_br_taken), .fc_i_br_target(fc_i_br_target),
    .fc_i_jmp(fc_i_jmp), .fc_i_jmp_target(fc_i_jmp_target),
    .fc_o_ce(fc_o_ce), .fc_o_change_pc(fc_o_change_pc), .fc_o_pc(fc_o_pc),
    .fc_o_flush_if(fc_o_flush_if), .fc_o_flush_id(fc_o_flush_id),
    .fc_o_state(fc_o_state), .fc_o_pending(fc_o_pending)
  );

  always #5 fc_clk = ~fc_clk;

  function automatic exp_t mk(input logic ce, input logic chg, input logic [31:0] pc,
                              input logic fif, input logic fid, input logic [1:0] st,
                              input logic pend);
    exp_t e;
    e.ce = ce; e.chg = chg; e.pc = pc; e.fif = fif; e.fid = fid; e.st = st; e.pend = pend;
    return e;
  endfunction

  task automatic drive(input logic stall, input logic rdy, input logic exc,
                       input logic br, input logic [31:0] brt,
                       input logic jmp, input logic [31:0] jt);
    fc_i_stall = stall; fc_i_imem_rdy = rdy; fc_i_exc = exc;
    fc_i_br_taken = br; fc_i_br_target = brt; fc_i_jmp = jmp; fc_i_jmp_target = jt;
  endtask

  // Queue the expectation, compare at the falling edge, then step past the rising edge.
  task automatic cyc(input string tag, input exp_t e);
    exp_t  want;
    exp_t  obs;
    string t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge fc_clk);
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    obs  = mk(fc_o_ce, fc_o_change_pc, fc_o_pc, fc_o_flush_if, fc_o_flush_id,
              fc_o_state, fc_o_pending);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", t, obs, want);
    end
    @(posedge fc_clk);
    #1;
  endtask

  task automatic boot_seq(input string pfx);
    cyc({pfx, "_boot0"}, mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0));
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 1'b1, 32'h20);
    cyc({pfx, "_boot1"}, mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0));
    cyc({pfx, "_fire"},  mk(1'b1, 1'b1, 32'h0, 1'b1, 1'b1, 2'b00, 1'b0));
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc({pfx, "_run"},   mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'b01, 1'b0));
  endtask

  initial begin
    fc_rst = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    cyc("rst_a", mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0));
    cyc("rst_b", mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0));
    fc_rst = 1'b1;
    boot_seq("b1");

    // Branch in RUN, no stall
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
    cyc("br_issue", mk(1'b1, 1'b1, 32'h40, 1'b1, 1'b1, 2'b01, 1'b0));
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc("br_after", mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'b01, 1'b0));

    // Jump under stall, released three cycles later
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h20);
    cyc("jmp_latch", mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b01, 1'b0));
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc("jmp_hold1", mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b10, 1'b1));
    cyc("jmp_hold2", mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b10, 1'b1));
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc("jmp_issue", mk(1'b1, 1'b1, 32'h20, 1'b1, 1'b0, 2'b10, 1'b1));
    cyc("jmp_after", mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'b01, 1'b0));

    // Simultaneous exc+br+jmp
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 1'b1, 32'h20);
    cyc("all3", mk(1'b1, 1'b1, 32'h80, 1'b1, 1'b1, 2'b01, 1'b0));
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc("all3_after", mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'b01, 1'b0));

    // HOLD override: pending jmp replaced by br
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h20);
    cyc("ovr_latch", mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b01, 1'b0));
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h44, 1'b0, 32'h0);
    cyc("ovr_br", mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b10, 1'b1));
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc("ovr_issue", mk(1'b1, 1'b1, 32'h44, 1'b1, 1'b1, 2'b10, 1'b1));
    cyc("ovr_after", mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'b01, 1'b0));

    // Reverse: pending br keeps priority over a later jmp
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h44, 1'b0, 32'h0);
    cyc("rev_latch", mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b01, 1'b0));
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h20);
    cyc("rev_jmp", mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b10, 1'b1));
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc("rev_issue", mk(1'b1, 1'b1, 32'h44, 1'b1, 1'b1, 2'b10, 1'b1));
    cyc("rev_after", mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'b01, 1'b0));

    // Tie at release: live jmp beats pending jmp; pending one is not replayed
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h20);
    cyc("tie_latch", mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b01, 1'b0));
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h24);
    cyc("tie_issue", mk(1'b1, 1'b1, 32'h24, 1'b1, 1'b0, 2'b10, 1'b1));
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc("tie_after", mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'b01, 1'b0));

    // imem not ready for two cycles in RUN
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc("rdy0_a", mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b01, 1'b0));
    cyc("rdy0_b", mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b01, 1'b0));
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc("rdy1", mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'b01, 1'b0));

    // Reset asserted while an exception is parked in HOLD
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc("exc_latch", mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b01, 1'b0));
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc("exc_hold", mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b10, 1'b1));
    fc_rst = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc("mid_rst", mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0));
    fc_rst = 1'b1;
    boot_seq("b2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
